busb_skid_mux: RTL and testbench

Parametrised, registered successor to the combinational bus-B source selector. It selects one of `NUM_SRC` source registers onto bus B, zero- or sign-extending narrow sources. The selected word is delivered through a valid/ready handshake with a two-entry skid buffer, so the datapath controller and the ALU B-operand port can stall independently. It also flags illegal selects and counts completed transfers.

---
 rtl/busb_skid_mux_if.sv | 34 +++
 rtl/busb_skid_mux.sv | 98 +++++++++
 tb/tb_busb_skid_mux.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/busb_skid_mux_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | busb_skid_mux_if : source/select request and bus-B delivery signals
// | Revision 1.0
// +-----------------------------------------------------------------------------
interface busb_skid_mux_if #(
  parameter int DATA_W  = 16,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*DATA_W-1:0] src;
  logic [SEL_W-1:0]          flagb;
  logic                      sext;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         busb;
  logic                      busb_valid;
  logic                      busb_ready;
  logic                      sel_err;
  logic                      err_clr;
  logic [CNT_W-1:0]          xfer_cnt;

  modport master (
    output src, flagb, sext, in_valid, busb_ready, err_clr,
    input  in_ready, busb, busb_valid, sel_err, xfer_cnt
  );

  modport slave (
    input  src, flagb, sext, in_valid, busb_ready, err_clr,
    output in_ready, busb, busb_valid, sel_err, xfer_cnt
  );
endinterface
`default_nettype wire

// File: rtl/busb_skid_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | busb_skid_mux : registered bus-B source selector with 2-entry skid buffer
// | Revision 1.0
// +-----------------------------------------------------------------------------
module busb_skid_mux #(
  parameter int          DATA_W      = 16,
  parameter int          NUM_SRC     = 8,
  parameter int          SEL_W       = 3,
  parameter int          NARROW_W    = 8,
  parameter logic [15:0] NARROW_MASK = 16'h00C0,
  parameter int          CNT_W       = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  busb_skid_mux_if.slave  bus
);

  logic [DATA_W-1:0] w_word;
  logic              w_illegal;
  logic              w_accept;
  logic              w_out_hs;

  logic [DATA_W-1:0] r_busb;
  logic              r_busb_valid;
  logic [DATA_W-1:0] r_skid;
  logic              r_skid_full;
  logic              r_sel_err;
  logic [CNT_W-1:0]  r_xfer_cnt;

  // Any select with no matching slot stays flagged illegal and yields zero.
  always_comb begin
    w_word    = '0;
    w_illegal = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.flagb == SEL_W'(i)) begin
        w_illegal = 1'b0;
        if (NARROW_MASK[i]) begin
          w_word = {{(DATA_W-NARROW_W){bus.sext & bus.src[i*DATA_W+NARROW_W-1]}},
                    bus.src[i*DATA_W +: NARROW_W]};
        end else begin
          w_word = bus.src[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign w_accept = bus.in_valid & ~r_skid_full;
  assign w_out_hs = r_busb_valid & bus.busb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busb       <= '0;
      r_busb_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_full  <= 1'b0;
    end else if (r_skid_full && bus.busb_ready) begin
      r_busb       <= r_skid;
      r_busb_valid <= 1'b1;
      r_skid_full  <= 1'b0;
    end else if (w_accept && (!r_busb_valid || bus.busb_ready)) begin
      r_busb       <= w_word;
      r_busb_valid <= 1'b1;
    end else if (w_accept) begin
      r_skid       <= w_word;
      r_skid_full  <= 1'b1;
    end else if (w_out_hs) begin
      r_busb_valid <= 1'b0;
    end
  end

  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_sel_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_out_hs) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready   = ~r_skid_full;
  assign bus.busb       = r_busb;
  assign bus.busb_valid = r_busb_valid;
  assign bus.sel_err    = r_sel_err;
  assign bus.xfer_cnt   = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_busb_skid_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_busb_skid_mux : directed + random bench for two busb_skid_mux configs
// | Revision 1.0
// +-----------------------------------------------------------------------------
module tb_busb_skid_mux;

  logic         clk;
  logic         rst_n;
  logic [127:0] src_all;
  logic [2:0]   flagb;
  logic         sext;
  logic         in_valid;
  logic         busb_ready;
  logic         err_clr;

  int total = 0;
  int bad   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        err0, err1;
  int          cnt0, cnt1;

  busb_skid_mux_if #(.DATA_W(16), .NUM_SRC(8), .SEL_W(3), .CNT_W(16)) bif0 ();
  busb_skid_mux_if #(.DATA_W(16), .NUM_SRC(6), .SEL_W(3), .CNT_W(4))  bif1 ();

  assign bif0.src        = src_all;
  assign bif0.flagb      = flagb;
  assign bif0.sext       = sext;
  assign bif0.in_valid   = in_valid;
  assign bif0.busb_ready = busb_ready;
  assign bif0.err_clr    = err_clr;
  assign bif1.src        = src_all[95:0];
  assign bif1.flagb      = flagb;
  assign bif1.sext       = sext;
  assign bif1.in_valid   = in_valid;
  assign bif1.busb_ready = busb_ready;
  assign bif1.err_clr    = err_clr;

  busb_skid_mux #(
    .DATA_W(16), .NUM_SRC(8), .SEL_W(3), .NARROW_W(8),
    .NARROW_MASK(16'h00C0), .CNT_W(16)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bif0));

  busb_skid_mux #(
    .DATA_W(16), .NUM_SRC(6), .SEL_W(3), .NARROW_W(8),
    .NARROW_MASK(16'h0020), .CNT_W(4)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word the bus should carry for a given select, straight from the selection rules.
  function automatic logic [15:0] mk_word(input int n_src, input logic [15:0] mask,
                                          input logic [127:0] s, input logic [2:0] f,
                                          input logic sx, output logic ill);
    logic [15:0] slot;
    ill = (int'(f) >= n_src);
    if (ill) return 16'h0000;
    slot = s[int'(f)*16 +: 16];
    if (!mask[f]) return slot;
    if (sx && slot[7]) return {8'hFF, slot[7:0]};
    return {8'h00, slot[7:0]};
  endfunction

  task automatic check_all();
    chk("in_ready0", {31'd0, bif0.in_ready}, {31'd0, q0.size() < 2});
    chk("valid0", {31'd0, bif0.busb_valid}, {31'd0, q0.size() > 0});
    if (q0.size() > 0) chk("busb0", {16'd0, bif0.busb}, {16'd0, q0[0]});
    chk("sel_err0", {31'd0, bif0.sel_err}, {31'd0, err0});
    chk("cnt0", {16'd0, bif0.xfer_cnt}, cnt0);
    chk("in_ready1", {31'd0, bif1.in_ready}, {31'd0, q1.size() < 2});
    chk("valid1", {31'd0, bif1.busb_valid}, {31'd0, q1.size() > 0});
    if (q1.size() > 0) chk("busb1", {16'd0, bif1.busb}, {16'd0, q1[0]});
    chk("sel_err1", {31'd0, bif1.sel_err}, {31'd0, err1});
    chk("cnt1", {28'd0, bif1.xfer_cnt}, cnt1);
  endtask

  // One clock: model the transfer from the inputs currently applied, then compare.
  task automatic step();
    logic        acc, hs, ill0, ill1;
    logic [15:0] w0, w1;
    acc = in_valid && (q0.size() < 2);
    hs  = busb_ready && (q0.size() > 0);
    w0  = mk_word(8, 16'h00C0, src_all, flagb, sext, ill0);
    w1  = mk_word(6, 16'h0020, src_all, flagb, sext, ill1);
    @(posedge clk);
    #1;
    if (hs) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
      cnt0 = (cnt0 + 1) % 65536;
      cnt1 = (cnt1 + 1) % 16;
    end
    if (acc) begin
      q0.push_back(w0);
      q1.push_back(w1);
    end
    if (acc && ill0) err0 = 1'b1; else if (err_clr) err0 = 1'b0;
    if (acc && ill1) err1 = 1'b1; else if (err_clr) err1 = 1'b0;
    check_all();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    err0 = 1'b0;
    err1 = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
  endtask

  task automatic set_slot(input int i, input logic [15:0] v);
    src_all[i*16 +: 16] = v;
  endtask

  initial begin
    rst_n = 1'b0; src_all = '0; flagb = '0; sext = 1'b0;
    in_valid = 1'b0; busb_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busb", {16'd0, bif0.busb}, 32'h0);
    chk("rst_valid", {31'd0, bif0.busb_valid}, 32'h0);
    chk("rst_in_ready", {31'd0, bif0.in_ready}, 32'h1);
    chk("rst_cnt", {16'd0, bif0.xfer_cnt}, 32'h0);
    rst_n = 1'b1;

    // Single wide transfer.
    set_slot(1, 16'hBEEF); flagb = 3'd1; in_valid = 1'b1; busb_ready = 1'b1;
    step();
    chk("beef", {16'd0, bif0.busb}, 32'hBEEF);
    in_valid = 1'b0;
    step();
    chk("beef_cnt", {16'd0, bif0.xfer_cnt}, 32'h1);

    // Narrow slot extension.
    flagb = 3'd6; in_valid = 1'b1; set_slot(6, 16'hFF85); sext = 1'b0;
    step();
    chk("zext", {16'd0, bif0.busb}, 32'h0085);
    sext = 1'b1;
    step();
    chk("sext_neg", {16'd0, bif0.busb}, 32'hFF85);
    set_slot(6, 16'h0042);
    step();
    chk("sext_pos", {16'd0, bif0.busb}, 32'h0042);
    in_valid = 1'b0;
    step();

    // Backpressure: A on bus, B in skid, C held off.
    flagb = 3'd2; in_valid = 1'b1; set_slot(2, 16'hAAA1);
    step();
    busb_ready = 1'b0; set_slot(2, 16'hBBB2);
    step();
    set_slot(2, 16'hCCC3);
    step();
    chk("bp_in_ready", {31'd0, bif0.in_ready}, 32'h0);
    chk("bp_hold_a", {16'd0, bif0.busb}, 32'hAAA1);
    step();
    chk("bp_still_a", {16'd0, bif0.busb}, 32'hAAA1);
    busb_ready = 1'b1;
    step();
    chk("bp_b", {16'd0, bif0.busb}, 32'hBBB2);
    step();
    chk("bp_c", {16'd0, bif0.busb}, 32'hCCC3);
    in_valid = 1'b0;
    step();

    // Illegal select on the 6-slot instance.
    flagb = 3'd7; set_slot(7, 16'h1234); in_valid = 1'b1;
    step();
    chk("ill_word", {16'd0, bif1.busb}, 32'h0);
    chk("ill_err", {31'd0, bif1.sel_err}, 32'h1);
    err_clr = 1'b1;
    step();
    chk("ill_set_wins", {31'd0, bif1.sel_err}, 32'h1);
    in_valid = 1'b0;
    step();
    chk("ill_clr", {31'd0, bif1.sel_err}, 32'h0);
    err_clr = 1'b0;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      src_all    = {$urandom, $urandom, $urandom, $urandom};
      flagb      = 3'($urandom_range(0, 7));
      sext       = 1'($urandom_range(0, 1));
      in_valid   = ($urandom_range(0, 3) != 0);
      busb_ready = ($urandom_range(0, 4) < 3);
      err_clr    = ($urandom_range(0, 19) == 0);
      step();
    end

    // Fill the skid, then reset asynchronously between edges.
    flagb = 3'd7; in_valid = 1'b1; busb_ready = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    chk("pre_rst_full", {31'd0, bif0.in_ready}, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bif0.busb_valid}, 32'h0);
    chk("arst_busb", {16'd0, bif0.busb}, 32'h0);
    chk("arst_in_ready", {31'd0, bif0.in_ready}, 32'h1);
    chk("arst_err", {31'd0, bif1.sel_err}, 32'h0);
    chk("arst_cnt", {16'd0, bif0.xfer_cnt}, 32'h0);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming after reset; the 4-bit counter wraps.
    flagb = 3'd3; in_valid = 1'b1; busb_ready = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      set_slot(3, 16'(16'h5000 + k));
      step();
      chk("stream_word", {16'd0, bif0.busb}, 32'h5000 + k);
      if (k == 16) chk("cnt_15", {28'd0, bif1.xfer_cnt}, 32'd15);
      if (k == 17) chk("cnt_wrap0", {28'd0, bif1.xfer_cnt}, 32'd0);
      if (k == 18) chk("cnt_wrap1", {28'd0, bif1.xfer_cnt}, 32'd1);
    end
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
